// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if
//   Request/response bus between the RV32I memory stage and the data memory.
//   The core drives the request on every cycle. Load data and the error flag
//   come back one cycle later.
//   Signals:
//     addr         [9:0]  byte address (core data_address)
//     width        [3:0]  right-aligned lane code: 0001 byte, 0011 half, 1111 word
//     write_mem           store strobe for the current cycle
//     wr_data      [31:0] right-aligned store data (core data_out)
//     rd_data      [31:0] right-aligned, zero-extended load data (core data_in)
//     misalign_err        registered pulse for a misaligned or illegal access
//   Modports: master (core side), slave (memory side).
interface data_memory_unit_if;
  logic [9:0]  addr;
  logic [3:0]  width;
  logic        write_mem;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        misalign_err;

  modport master (
    output addr, width, write_mem, wr_data,
    input  rd_data, misalign_err
  );

  modport slave (
    input  addr, width, write_mem, wr_data,
    output rd_data, misalign_err
  );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Byte-addressed 1 KiB data memory for the RV32I core. Stores use byte-lane
//   steering and are dropped if they are misaligned. Loads run every cycle with
//   1-cycle latency and read-first behaviour. The result is right-aligned and
//   zero-extended for the writeback stage.
//   Ports:
//     clk        rising-edge clock shared with the core
//     rst_n      asynchronous active-low reset
//     bus        data_memory_unit_if.slave request/response bus
//     err_count  saturating count of misalign_err pulses
//     led_out    MMIO LED register (0 unless DMEM_MMIO_EN)
//   Build option:
//     DMEM_MMIO_EN  maps bytes 0x3F0-0x3FF to an MMIO window instead of RAM
//                   words 252-255:
//                     0x3F0 LED register (read/write)
//                     0x3F4 free-running cycle counter (read-only)
//                     0x3F8 error count (read-only)
//                     0x3FC reads as zero
module data_memory_unit #(
  parameter int WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_unit_if.slave   bus,
  output logic [7:0]          err_count,
  output logic [31:0]         led_out
);

  logic [7:0]  word_idx;
  logic [1:0]  offset;
  logic        width_legal;
  logic        misaligned;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_sh;
  logic        store_ok;
  logic        ram_we;

  logic [31:0] mem [WORDS];
  logic [31:0] ram_q;
  logic [1:0]  off_q;
  logic [3:0]  width_q;
  logic        misalign_q;
  logic [31:0] word_q;

  assign word_idx = bus.addr[9:2];
  assign offset   = bus.addr[1:0];

  always_comb begin
    width_legal = (bus.width == 4'b0001) || (bus.width == 4'b0011) ||
                  (bus.width == 4'b1111);
    misaligned  = !width_legal ||
                  ((bus.width == 4'b0011) && bus.addr[0]) ||
                  ((bus.width == 4'b1111) && (offset != 2'b00));
  end

  // Aligned accesses never shift lane bits past bit 3, so truncation is safe.
  assign lane_mask = bus.width << offset;
  assign wdata_sh  = bus.wr_data << {offset, 3'b000};
  assign store_ok  = bus.write_mem && !misaligned;

`ifdef DMEM_MMIO_EN
  logic        mmio_hit;
  logic        mmio_sel_q;
  logic [31:0] mmio_q;
  logic [31:0] led_q;
  logic [31:0] cycle_cnt;

  assign mmio_hit = (bus.addr[9:4] == 6'h3F);
  assign ram_we   = store_ok && !mmio_hit;

  // The MMIO read value is captured at the same edge as the RAM word, so
  // MMIO reads have the same latency and read-first behaviour as RAM reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      cycle_cnt  <= '0;
      mmio_sel_q <= 1'b0;
      mmio_q     <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      mmio_sel_q <= mmio_hit;
      case (bus.addr[3:2])
        2'd0:    mmio_q <= led_q;
        2'd1:    mmio_q <= cycle_cnt;
        2'd2:    mmio_q <= {24'b0, err_count};
        default: mmio_q <= '0;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (store_ok && mmio_hit && (bus.addr[3:2] == 2'd0) && lane_mask[i])
          led_q[8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign led_out = led_q;
  assign word_q  = mmio_sel_q ? mmio_q : ram_q;
`else
  assign ram_we  = store_ok;
  assign led_out = '0;
  assign word_q  = ram_q;
`endif

  // RAM has no reset. The old word is read before the write lands (read-first).
  always_ff @(posedge clk) begin
    ram_q <= mem[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (ram_we && lane_mask[i])
        mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  // For a misaligned load, the captured width is forced to zero. The extraction
  // mask is then empty and rd_data reads 0, which is also the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= 2'b00;
      width_q    <= 4'b0000;
      misalign_q <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      off_q      <= offset;
      width_q    <= (misaligned && !bus.write_mem) ? 4'b0000 : bus.width;
      misalign_q <= misaligned;
      if (misaligned && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  assign bus.rd_data = (word_q >> {off_q, 3'b000}) &
                       {{8{width_q[3]}}, {8{width_q[2]}},
                        {8{width_q[1]}}, {8{width_q[0]}}};
  assign bus.misalign_err = misalign_q;

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Byte-addressed data memory for the RV32I core, directly downstream of the core's memory stage. It consumes the core's store/load request: `data_address`, `width`, `write_mem` and `data_out`. It returns load data on the core's `data_in` one cycle later, aligned for the writeback stage. Stores use byte-lane steering and misalignment checking. An optional memory-mapped I/O window holds an LED register and a cycle counter.

## Interface
- `WORDS`, 256: number of 32-bit words. Address space is 4*WORDS bytes and must equal 1024.
- `clk`  in  1  rising-edge clock, shared with the core.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `addr`  in  10  byte address from the core's `data_address`.
- `width`  in  4  access-width code from the core, right-aligned: 0001 = byte, 0011 = half, 1111 = word. Any other code is illegal.
- `write_mem`  in  1  store strobe for the current cycle.
- `wr_data`  in  32  store data from the core's `data_out`, right-aligned.
- `rd_data`  out  32  load data to the core's `data_in`, right-aligned and zero-extended.
- `misalign_err`  out  1  one-cycle pulse flagging a misaligned or illegal access.
- `err_count`  out  8  saturating count of `misalign_err` pulses.
- `led_out`  out  32  MMIO LED register. Tied to 0 without the `DMEM_MMIO_EN` macro.

## Operation
- Word index = `addr[9:2]`; byte offset = `addr[1:0]`.
- Alignment rules:
  - Half-word access is misaligned if `addr[0]` = 1.
  - Word access is misaligned if `addr[1:0]` != 0.
  - An illegal `width` code counts as misaligned.
- Store, when `write_mem` = 1 and the access is aligned:
  - Lane mask = `width` << `addr[1:0]`.
  - Write data = `wr_data` << (8*`addr[1:0]`).
  - Only masked bytes change.
- Misaligned store: memory is unchanged; `misalign_err` pulses.
- Load runs every cycle.
  - Captured at the edge: RAM word, `addr[1:0]`, `width`.
  - `rd_data` = captured word >> (8*offset), ANDed with the byte mask of the captured width.
  - Sign extension belongs to the writeback stage.
- Misaligned load: `rd_data` = 0; `misalign_err` pulses. This applies to loads only when `write_mem` = 0.
- Read during write to the same word is read-first: `rd_data` carries the old contents.
- `err_count` increments on each `misalign_err` pulse and saturates at 255.
- RAM contents are not reset.

## Timing
- Store takes effect at the rising edge that samples `write_mem` = 1.
- Load latency is 1 cycle: address at edge N, `rd_data` valid after edge N. This matches the core's MEM→WB register.
- `misalign_err` is registered and asserts for the cycle after the offending request.
- Back-to-back accesses every cycle are supported; there are no stalls and no handshake.
- Reset asserted at any time clears immediately, regardless of an in-flight access. The following outputs go to 0:
  - `rd_data`, `misalign_err`, `err_count`, `led_out`.
  - Captured offset/width registers.
  - Cycle counter.
- After `rst_n` rises, the first edge behaves normally.

## Configuration
- `DMEM_MMIO_EN` defined: byte addresses 0x3F0–0x3FF form the MMIO window, replacing RAM words 252–255.
  - 0x3F0: `led_out`. Read/write, byte-lane stores honoured.
  - 0x3F4: 32-bit free-running cycle counter. Increments every cycle, wraps 0xFFFFFFFF→0, read-only; stores ignored.
  - 0x3F8: {24'b0, `err_count`}. Read-only.
  - 0x3FC: reads 0; stores ignored.
  - MMIO reads share the 1-cycle latency and offset/width extraction of RAM reads.
- `DMEM_MMIO_EN` undefined:
  - All 256 words are RAM.
  - `led_out` = 0 constantly.
  - No counter logic.

## Test plan
- Reset values: hold `rst_n` = 0, then release → `rd_data` = 0, `err_count` = 0, `led_out` = 0, `misalign_err` = 0.
- Word round-trip: store word 0xDEADBEEF @0x010, then load word @0x010 → `rd_data` = 0xDEADBEEF one cycle after the load address.
- Byte/half lanes, starting from word 0xDEADBEEF @0x010:
  - Store byte 0x55 @0x012; load word @0x010 → 0xDE55BEEF.
  - Load half @0x012 → 0x0000DE55.
  - Load byte @0x013 → 0x000000DE.
- Misalignment, starting from word 0xDE55BEEF @0x010:
  - Store word 0x12345678 @0x011 → `misalign_err` pulses 1 cycle, `err_count` = 1.
  - Load word @0x010 → 0xDE55BEEF, unchanged.
  - Repeat the misaligned store 300 times → `err_count` = 255.
- Read-first: store 0xAAAAAAAA @0x020 and load @0x020 in the same cycle → old value returned; the next load → 0xAAAAAAAA.
- MMIO, with `DMEM_MMIO_EN` defined:
  - Store word 0x0000F00D @0x3F0 → `led_out` = 0x0000F00D.
  - Two loads of @0x3F4 issued 5 cycles apart → values differ by 5.
  - Store @0x3F4 → counter unaffected.
